// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback path: request record, source
// identifiers and the hard-wired zero register index.
package wb_pkg;

  localparam int WB_XLEN = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]         rd;
    logic [WB_XLEN-1:0] data;
  } wb_req_t;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_skid_slot.sv
// One-entry writeback buffer. A load wins over a drain at the same edge,
// which lets the slot be emptied and refilled in a single cycle.
module wb_skid_slot #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_drain,
  input  logic [4:0]      i_rd,
  input  logic [XLEN-1:0] i_data,
  output logic            o_full,
  output logic [4:0]      o_rd,
  output logic [XLEN-1:0] o_data
);

  logic            r_full;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 1'b0;
      r_rd   <= '0;
      r_data <= '0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_rd   <= i_rd;
      r_data <= i_data;
    end else if (i_drain) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_rd   = r_rd;
  assign o_data = r_data;

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and LSU writebacks onto a single register-file write port with
// round-robin conflict resolution, a pending-register mask and a conflict counter.
// Handshake: a request transfers at a rising edge where valid & ready are both
// high; ready depends only on registered state, never on valid.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [XLEN-1:0]  alu_data,
  output logic             alu_ready,
  input  logic             lsu_valid,
  input  logic [4:0]       lsu_rd,
  input  logic [XLEN-1:0]  lsu_data,
  output logic             lsu_ready,
  output logic             w_en,
  output logic [4:0]       addr_w,
  output logic [XLEN-1:0]  w_data,
  output logic [31:0]      pend_mask,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic            w_alu_full, w_lsu_full;
  logic [4:0]      w_alu_q_rd, w_lsu_q_rd;
  logic [XLEN-1:0] w_alu_q_data, w_lsu_q_data;
  logic            w_alu_gnt, w_lsu_gnt, w_any_gnt, w_both_full;
  logic            w_alu_load, w_lsu_load;
  wb_src_e         w_gnt_src;
  logic [31:0]     w_set_mask, w_clr_mask;

  logic             r_rr_pri;
  logic             r_w_en;
  logic [4:0]       r_addr_w;
  logic [XLEN-1:0]  r_w_data;
  logic [31:0]      r_pend_mask;
  logic [CNT_W-1:0] r_conflict_cnt;

  wb_skid_slot #(.XLEN(XLEN)) u_alu_slot (
    .clk(clk), .rst(rst), .i_load(w_alu_load), .i_drain(w_alu_gnt),
    .i_rd(alu_rd), .i_data(alu_data),
    .o_full(w_alu_full), .o_rd(w_alu_q_rd), .o_data(w_alu_q_data)
  );

  wb_skid_slot #(.XLEN(XLEN)) u_lsu_slot (
    .clk(clk), .rst(rst), .i_load(w_lsu_load), .i_drain(w_lsu_gnt),
    .i_rd(lsu_rd), .i_data(lsu_data),
    .o_full(w_lsu_full), .o_rd(w_lsu_q_rd), .o_data(w_lsu_q_data)
  );

  // rr_pri = 1 favours the ALU when both slots hold a request.
  always_comb begin
    w_both_full = w_alu_full & w_lsu_full;
    w_alu_gnt   = w_alu_full & (~w_lsu_full | r_rr_pri);
    w_lsu_gnt   = w_lsu_full & ~w_alu_gnt;
    w_any_gnt   = w_alu_gnt | w_lsu_gnt;
    w_gnt_src   = w_alu_gnt ? WB_SRC_ALU : WB_SRC_LSU;
  end

  assign alu_ready  = ~w_alu_full | w_alu_gnt;
  assign lsu_ready  = ~w_lsu_full | w_lsu_gnt;
  // Writes to x0 complete the handshake but are dropped here.
  assign w_alu_load = alu_valid & alu_ready & (alu_rd != REG_ZERO);
  assign w_lsu_load = lsu_valid & lsu_ready & (lsu_rd != REG_ZERO);

  // A retiring write may only clear its pend bit if no buffered slot still targets it.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (w_alu_load) w_set_mask[alu_rd] = 1'b1;
    if (w_lsu_load) w_set_mask[lsu_rd] = 1'b1;
    if (r_w_en &&
        !(w_alu_full && (w_alu_q_rd == r_addr_w)) &&
        !(w_lsu_full && (w_lsu_q_rd == r_addr_w)))
      w_clr_mask[r_addr_w] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_pri       <= 1'b0;
      r_w_en         <= 1'b0;
      r_addr_w       <= '0;
      r_w_data       <= '0;
      r_pend_mask    <= '0;
      r_conflict_cnt <= '0;
    end else begin
      r_w_en      <= w_any_gnt;
      r_pend_mask <= (r_pend_mask & ~w_clr_mask) | w_set_mask;
      if (w_any_gnt) begin
        r_addr_w <= (w_gnt_src == WB_SRC_ALU) ? w_alu_q_rd   : w_lsu_q_rd;
        r_w_data <= (w_gnt_src == WB_SRC_ALU) ? w_alu_q_data : w_lsu_q_data;
      end
      if (w_both_full) begin
        r_rr_pri <= ~r_rr_pri;
        if (r_conflict_cnt != '1) r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
      end
    end
  end

  assign w_en         = r_w_en;
  assign addr_w       = r_addr_w;
  assign w_data       = r_w_data;
  assign pend_mask    = r_pend_mask;
  assign conflict_cnt = r_conflict_cnt;

endmodule
